// File: rtl/fifo_sc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sc_ctrl_pkg
//  Brief    : Shared defaults, status struct and threshold helper for the
//             single-clock FIFO controller.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_sc_ctrl_pkg;

  // Default geometry: 32 entries of 16 bits
  localparam int FIFO_AW_DEFAULT = 5;
  localparam int FIFO_DW_DEFAULT = 16;

  // Registered status flags, kept together so they update as one word
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

  // Threshold flags from an occupancy value: {almost_full, almost_empty}
  function automatic logic [1:0] calc_thresh(
    input int unsigned cnt,
    input int unsigned af_lvl,
    input int unsigned ae_lvl
  );
    return {(cnt >= af_lvl), (cnt <= ae_lvl)};
  endfunction

endpackage : fifo_sc_ctrl_pkg
`default_nettype wire

// File: rtl/fifo_sc_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sc_ptr
//  Brief    : aw+1-bit FIFO pointer (MSB is the wrap bit) with increment
//             enable, synchronous clear and asynchronous reset. Exposes both
//             the current and the next value so the owner can register
//             flags in the same edge as the pointer itself.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sc_ptr #(
  parameter int aw = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [aw:0] o_ptr,
  output logic [aw:0] o_ptr_nxt
);

  logic [aw:0] r_ptr;
  logic [aw:0] w_ptr_nxt;

  // Next pointer: clear wins, otherwise natural binary roll-over
  // carries the low bits from 2**aw-1 to 0 and toggles the wrap bit.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_clr) begin
      w_ptr_nxt = '0;
    end else if (i_inc) begin
      w_ptr_nxt = r_ptr + 1'b1;
    end
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_ptr     = r_ptr;
  assign o_ptr_nxt = w_ptr_nxt;

endmodule : fifo_sc_ptr
`default_nettype wire

// File: rtl/fifo_sc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sc_ctrl
//  Brief    : Single-clock FIFO controller driving both ports of a
//             synchronous dual-port RAM. Owns pointers, occupancy and flags,
//             forwards registered RAM read data with a one-cycle valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sc_ctrl
  import fifo_sc_ctrl_pkg::*;
#(
  parameter int aw     = FIFO_AW_DEFAULT,
  parameter int dw     = FIFO_DW_DEFAULT,
  parameter int AF_LVL = (2**aw) - 2,
  parameter int AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [dw-1:0] din,
  input  logic          pop,
  output logic [dw-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [aw:0]   count,
  output logic          ovf,
  output logic          unf,
  output logic [aw-1:0] ram_waddr,
  output logic [dw-1:0] ram_di,
  output logic          ram_we,
  output logic          ram_wce,
  output logic [aw-1:0] ram_raddr,
  output logic          ram_rce,
  output logic          ram_oe,
  input  logic [dw-1:0] ram_do
);

  localparam logic [aw:0] c_RST_COUNT = '0;

  logic         w_push_ok;
  logic         w_pop_ok;
  logic [aw:0]  w_wr_ptr;
  logic [aw:0]  w_rd_ptr;
  logic [aw:0]  w_wr_nxt;
  logic [aw:0]  w_rd_nxt;
  logic [aw:0]  w_cnt_nxt;
  logic [1:0]   w_thresh;
  fifo_status_t w_stat_nxt;

  fifo_status_t r_stat;
  logic [aw:0]  r_count;
  logic         r_dout_valid;

  // Request acceptance. Full/empty come from the registered flags, so a
  // push into a full FIFO is refused even if a pop frees a slot in the same
  // cycle (the addresses would collide), and a pop from an empty FIFO is
  // refused even with a same-cycle push. clr drops both requests; rst holds
  // the RAM strobes low combinationally.
  always_comb begin
    w_push_ok = push & ~r_stat.full  & ~clr & ~rst;
    w_pop_ok  = pop  & ~r_stat.empty & ~clr & ~rst;
    ovf       = push &  r_stat.full  & ~clr & ~rst;
    unf       = pop  &  r_stat.empty & ~clr & ~rst;
  end

  fifo_sc_ptr #(
    .aw        (aw)
  ) u_wr_ptr (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (clr),
    .i_inc     (w_push_ok),
    .o_ptr     (w_wr_ptr),
    .o_ptr_nxt (w_wr_nxt)
  );

  fifo_sc_ptr #(
    .aw        (aw)
  ) u_rd_ptr (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (clr),
    .i_inc     (w_pop_ok),
    .o_ptr     (w_rd_ptr),
    .o_ptr_nxt (w_rd_nxt)
  );

  // Status of the pointers as they will be after this edge; registering it
  // makes flags and count change in the same edge as the pointers.
  always_comb begin
    w_cnt_nxt               = w_wr_nxt - w_rd_nxt;
    w_thresh                = calc_thresh(32'(w_cnt_nxt), AF_LVL, AE_LVL);
    w_stat_nxt.empty        = (w_wr_nxt == w_rd_nxt);
    w_stat_nxt.full         = (w_wr_nxt[aw-1:0] == w_rd_nxt[aw-1:0]) &&
                              (w_wr_nxt[aw] != w_rd_nxt[aw]);
    w_stat_nxt.almost_full  = w_thresh[1];
    w_stat_nxt.almost_empty = w_thresh[0];
  end

  // Registered status, occupancy and read-data valid strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat.empty        <= 1'b1;
      r_stat.full         <= 1'b0;
      r_stat.almost_empty <= 1'b1;
      r_stat.almost_full  <= 1'b0;
      r_count             <= c_RST_COUNT;
      r_dout_valid        <= 1'b0;
    end else begin
      r_stat              <= w_stat_nxt;
      r_count             <= w_cnt_nxt;
      r_dout_valid        <= w_pop_ok;
    end
  end

  // RAM port drive and client-side outputs
  always_comb begin
    ram_we       = w_push_ok;
    ram_wce      = w_push_ok;
    ram_waddr    = w_wr_ptr[aw-1:0];
    ram_di       = din;
    ram_rce      = w_pop_ok;
    ram_raddr    = w_rd_ptr[aw-1:0];
    ram_oe       = 1'b1;
    dout         = ram_do;
    dout_valid   = r_dout_valid;
    full         = r_stat.full;
    empty        = r_stat.empty;
    almost_full  = r_stat.almost_full;
    almost_empty = r_stat.almost_empty;
    count        = r_count;
  end

endmodule : fifo_sc_ctrl
`default_nettype wire

// File: tb/tb_fifo_sc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sc_ctrl
//  Brief    : Self-checking bench for fifo_sc_ctrl with a behavioural RAM,
//             a queue-based reference FIFO and a read-data scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_sc_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int AFL   = 30;
  localparam int AEL   = 2;

  logic          clk = 1'b0;
  logic          rst, clr, push, pop;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          ovf, unf;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_di, ram_do;
  logic          ram_we, ram_wce, ram_rce, ram_oe;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mq [$];
  logic [DW-1:0] sb [$];
  int            wr_cnt, rd_cnt;
  int            vectors     = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  fifo_sc_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .push         (push),
    .din          (din),
    .pop          (pop),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .ovf          (ovf),
    .unf          (unf),
    .ram_waddr    (ram_waddr),
    .ram_di       (ram_di),
    .ram_we       (ram_we),
    .ram_wce      (ram_wce),
    .ram_raddr    (ram_raddr),
    .ram_rce      (ram_rce),
    .ram_oe       (ram_oe),
    .ram_do       (ram_do)
  );

  // Behavioural synchronous dual-port RAM with registered read data
  always @(posedge clk) begin
    if (ram_we && ram_wce) mem[ram_waddr] <= ram_di;
    if (ram_rce && ram_oe) ram_do <= mem[ram_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every read-data strobe must match the oldest expected word
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dout_unexpected: got valid data %0h expected no strobe", dout);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        chk("dout", {16'h0, dout}, {16'h0, e});
      end
    end
  end

  task automatic chk_state(input logic exp_dv);
    int n;
    n = mq.size();
    chk("count",        32'(count),        n);
    chk("empty",        32'(empty),        32'(n == 0));
    chk("full",         32'(full),         32'(n == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(n >= AFL));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AEL));
    chk("dout_valid",   32'(dout_valid),   32'(exp_dv));
  endtask

  // One clock of stimulus with combinational checks before the edge and
  // registered-state checks after it.
  task automatic do_cycle(input logic p, input logic q, input logic c, input logic [DW-1:0] d);
    logic acc_push, acc_pop;
    @(negedge clk);
    push = p; pop = q; clr = c; din = d;
    #1;
    acc_push = p && !c && (mq.size() < DEPTH);
    acc_pop  = q && !c && (mq.size() > 0);
    chk("ovf",     32'(ovf),     32'(p && !c && mq.size() == DEPTH));
    chk("unf",     32'(unf),     32'(q && !c && mq.size() == 0));
    chk("ram_we",  32'(ram_we),  32'(acc_push));
    chk("ram_wce", 32'(ram_wce), 32'(acc_push));
    chk("ram_rce", 32'(ram_rce), 32'(acc_pop));
    chk("no_collision", 32'(ram_we && ram_rce && (ram_waddr == ram_raddr)), 0);
    if (acc_push) begin
      chk("ram_waddr", 32'(ram_waddr), wr_cnt % DEPTH);
      chk("ram_di",    32'(ram_di),    32'(d));
    end
    if (acc_pop) chk("ram_raddr", 32'(ram_raddr), rd_cnt % DEPTH);
    @(posedge clk);
    if (c) begin
      mq.delete();
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      if (acc_pop)  begin sb.push_back(mq.pop_front()); rd_cnt++; end
      if (acc_push) begin mq.push_back(d);              wr_cnt++; end
    end
    #1;
    chk_state(acc_pop);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    wr_cnt = 0; rd_cnt = 0;
    #1;
    chk_state(1'b0);
    chk("rst_we", 32'(ram_we), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill 0x0000..0x001F, then an overflowing push
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 1'b0, DW'(i));
    do_cycle(1'b1, 1'b0, 1'b0, 16'hDEAD);
    // Full with push+pop: push refused, pop accepted
    do_cycle(1'b1, 1'b1, 1'b0, 16'hBEEF);
    do_cycle(1'b1, 1'b0, 1'b0, 16'h0020);
    // Drain everything, then an underflowing pop
    for (int i = 0; i < DEPTH + 1; i++) do_cycle(1'b0, 1'b1, 1'b0, '0);
    // Empty with push+pop: pop refused, pushed word available next cycle
    do_cycle(1'b1, 1'b1, 1'b0, 16'h1234);
    do_cycle(1'b0, 1'b1, 1'b0, '0);
    // Streaming across pointer wrap at constant occupancy 3
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
    for (int i = 0; i < 100; i++) do_cycle(1'b1, 1'b1, 1'b0, DW'($urandom));
    // Clear together with push at occupancy 10
    while (mq.size() < 10) do_cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
    do_cycle(1'b1, 1'b0, 1'b1, 16'hC1C1);
    do_cycle(1'b0, 1'b0, 1'b0, '0);

    // Randomised traffic with alternating fill/drain bias and rare clears
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 100; i++) begin
        logic p, q, c;
        p = ($urandom_range(0, 99) < ((blk % 2 == 0) ? 75 : 35));
        q = ($urandom_range(0, 99) < ((blk % 2 == 0) ? 35 : 75));
        c = ($urandom_range(0, 199) == 0);
        do_cycle(p, q, c, DW'($urandom));
      end
    end

    // Asynchronous reset between edges at occupancy 10 with a strobe pending
    while (mq.size() < 11) do_cycle(1'b1, 1'b0, 1'b0, DW'($urandom));
    while (mq.size() > 11) do_cycle(1'b0, 1'b1, 1'b0, '0);
    do_cycle(1'b0, 1'b1, 1'b0, '0);
    push = 1'b0; pop = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    mq.delete(); sb.delete(); wr_cnt = 0; rd_cnt = 0;
    chk_state(1'b0);
    chk("rst_we",  32'(ram_we),  0);
    chk("rst_rce", 32'(ram_rce), 0);
    @(negedge clk);
    rst = 1'b0;

    // Recovery after reset, then drain and settle
    for (int i = 0; i < 40; i++) do_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, DW'($urandom));
    while (mq.size() > 0) do_cycle(1'b0, 1'b1, 1'b0, '0);
    do_cycle(1'b0, 1'b0, 1'b0, '0);
    do_cycle(1'b0, 1'b0, 1'b0, '0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fifo_sc_ctrl
`default_nettype wire
